// File: rtl/ip_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ip_sequencer
//  Description : Fetch / bracket-seek controller sitting in front of the
//                NextOpcode block (IP counter + ROM + one-hot decoder).
//                A fetch steps the IP once and returns the decoded opcode.
//                A seek keeps stepping the IP (forward or backward) while
//                tracking bracket nesting until the matching bracket is
//                reached, or flags an error on HALT / nesting overflow.
//  Ports       : i_clk, i_rst        clock, asynchronous active-high reset
//                i_request           start a fetch (only while o_ready)
//                i_seek, i_dir       start a seek, 0=forward 1=backward
//                i_opcode[15:0]      decoded one-hot opcode from NextOpcode
//                o_count, o_reverse  IP step strobe / IP direction
//                o_load              ROM load strobe
//                o_insn[15:0]        last captured opcode
//                o_insn_valid        1-cycle pulse: fetch complete
//                o_seek_done         1-cycle pulse: matching bracket reached
//                o_ready             idle, accepting commands
//                o_error             sticky error (HALT during seek/overflow)
//  Revision    : 1.0  initial release
// ============================================================================
module ip_sequencer #(
    parameter int DEPTH_W   = 8,
    parameter int OPEN_BIT  = 4,
    parameter int CLOSE_BIT = 5,
    parameter int HALT_BIT  = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_request,
    input  logic        i_seek,
    input  logic        i_dir,
    input  logic [15:0] i_opcode,
    output logic        o_count,
    output logic        o_reverse,
    output logic        o_load,
    output logic [15:0] o_insn,
    output logic        o_insn_valid,
    output logic        o_seek_done,
    output logic        o_ready,
    output logic        o_error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_STEP = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [DEPTH_W-1:0] c_DEPTH_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] c_DEPTH_ZERO = '0;

    logic [2:0]         r_state;
    logic               r_seek_mode;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_count;
    logic               r_reverse;
    logic               r_load;
    logic [15:0]        r_insn;
    logic               r_insn_valid;
    logic               r_seek_done;
    logic               r_ready;
    logic               r_error;

    logic               w_halt;
    logic               w_open;
    logic               w_close;
    logic               w_inc;
    logic               w_dec;
    logic               w_depth_max;
    logic [DEPTH_W-1:0] w_depth_next;

    assign w_halt  = i_opcode[HALT_BIT];
    assign w_open  = i_opcode[OPEN_BIT];
    assign w_close = i_opcode[CLOSE_BIT];

    // Priority HALT > OPEN > CLOSE: when both brackets are flagged, only
    // OPEN is considered. During a seek r_reverse holds the seek direction,
    // so it selects which bracket nests deeper.
    always_comb begin
        w_inc = 1'b0;
        w_dec = 1'b0;
        if (!w_halt) begin
            if (r_reverse) begin
                w_dec = w_open;
                w_inc = !w_open && w_close;
            end else begin
                w_inc = w_open;
                w_dec = !w_open && w_close;
            end
        end
    end

    assign w_depth_max = &r_depth;

    always_comb begin
        w_depth_next = r_depth;
        if (w_inc) begin
            w_depth_next = r_depth + c_DEPTH_ONE;
        end else if (w_dec) begin
            w_depth_next = r_depth - c_DEPTH_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_seek_mode  <= 1'b0;
            r_depth      <= c_DEPTH_ZERO;
            r_count      <= 1'b0;
            r_reverse    <= 1'b0;
            r_load       <= 1'b0;
            r_insn       <= 16'h0000;
            r_insn_valid <= 1'b0;
            r_seek_done  <= 1'b0;
            r_ready      <= 1'b1;
            r_error      <= 1'b0;
        end else begin
            // Strobes and pulses default low; each is raised only on the
            // edge that enters the state owning it, so they stay one cycle.
            r_count      <= 1'b0;
            r_load       <= 1'b0;
            r_insn_valid <= 1'b0;
            r_seek_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_seek) begin
                        r_reverse   <= i_dir;
                        r_depth     <= c_DEPTH_ONE;
                        r_seek_mode <= 1'b1;
                        r_count     <= 1'b1;
                        r_ready     <= 1'b0;
                        r_state     <= S_STEP;
                    end else if (i_request) begin
                        r_reverse   <= 1'b0;
                        r_seek_mode <= 1'b0;
                        r_count     <= 1'b1;
                        r_ready     <= 1'b0;
                        r_state     <= S_STEP;
                    end
                end

                S_STEP: begin
                    r_load  <= 1'b1;
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_insn <= i_opcode;
                    if (!r_seek_mode) begin
                        r_insn_valid <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (w_halt || (w_inc && w_depth_max)) begin
                        // Unmatched bracket or nesting deeper than the
                        // counter can hold: never wrap, lock up instead.
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_depth <= w_depth_next;
                        if (w_depth_next == c_DEPTH_ZERO) begin
                            r_seek_done <= 1'b1;
                            r_ready     <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_count <= 1'b1;
                            r_state <= S_STEP;
                        end
                    end
                end

                S_ERR: begin
                    r_error <= 1'b1;
                    r_ready <= 1'b0;
                end

                default: begin
                    r_error <= 1'b1;
                    r_ready <= 1'b0;
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_reverse    = r_reverse;
    assign o_load       = r_load;
    assign o_insn       = r_insn;
    assign o_insn_valid = r_insn_valid;
    assign o_seek_done  = r_seek_done;
    assign o_ready      = r_ready;
    assign o_error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ip_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ip_sequencer
//  Description : Self-checking bench for ip_sequencer. A small NextOpcode
//                stand-in (IP register + ROM + decoder) reacts to the DUT
//                strobes; a behavioural model scans the ROM directly to
//                predict every command's outcome and cycle-by-cycle outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ip_sequencer;

    localparam int DW   = 2;
    localparam int MAXD = (1 << DW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request = 1'b0;
    logic        seek = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] opcode = 16'h0000;
    logic        o_count, o_reverse, o_load, o_insn_valid;
    logic        o_seek_done, o_ready, o_error;
    logic [15:0] o_insn;

    always #5 clk = ~clk;

    ip_sequencer #(.DEPTH_W(DW), .OPEN_BIT(4), .CLOSE_BIT(5), .HALT_BIT(0)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_request    (request),
        .i_seek       (seek),
        .i_dir        (dir),
        .i_opcode     (opcode),
        .o_count      (o_count),
        .o_reverse    (o_reverse),
        .o_load       (o_load),
        .o_insn       (o_insn),
        .o_insn_valid (o_insn_valid),
        .o_seek_done  (o_seek_done),
        .o_ready      (o_ready),
        .o_error      (o_error)
    );

    // ---------------- program ROM and decoder ----------------
    byte rom [64];
    int  rom_len = 0;

    function automatic logic [15:0] onehot(input byte ch);
        case (ch)
            "+": return 16'h0002;
            "-": return 16'h0004;
            ">": return 16'h0008;
            "[": return 16'h0010;
            "]": return 16'h0020;
            "<": return 16'h0040;
            ".": return 16'h0080;
            ",": return 16'h0100;
            default: return 16'h0001;
        endcase
    endfunction

    // Anything outside the program reads as HALT.
    function automatic logic [15:0] rom_op(input int p);
        if (p < 0 || p >= rom_len) return 16'h0001;
        return onehot(rom[p]);
    endfunction

    task automatic load_prog(input string s);
        rom_len = s.len();
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    // ---------------- NextOpcode stand-in ----------------
    int   env_ip = 0;
    logic env_set = 1'b0;
    int   env_set_val = 0;

    always @(posedge clk) begin
        if (env_set) env_ip <= env_set_val;
        else if (o_count) env_ip <= env_ip + (o_reverse ? -1 : 1);
        if (o_load) opcode <= rom_op(env_ip);
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'd0, o_count, o_load, o_reverse, o_insn_valid, o_seek_done,
                o_ready, o_error, o_insn};
    endfunction

    function automatic logic [31:0] mk(input logic cnt, input logic ld, input logic rv,
                                       input logic iv, input logic sd, input logic rdy,
                                       input logic er, input logic [15:0] ins);
        return {9'd0, cnt, ld, rv, iv, sd, rdy, er, ins};
    endfunction

    // ---------------- behavioural model ----------------
    int          m_ip   = 0;
    logic [15:0] m_insn = 16'h0000;
    logic        m_rev  = 1'b0;
    logic        m_err  = 1'b0;
    logic [15:0] m_ops [256];
    int          last_n = 0;

    // Walk the ROM from the starting bracket, counting nesting.
    // outcome: 0 = matched, 1 = error
    task automatic model_seek(input int start, input logic d,
                              output int n, output int endp, output int outcome);
        int depth;
        int p;
        logic [15:0] op;
        logic deeper, shallower;
        depth = 1; p = start; n = 0; outcome = 1;
        while (n < 250) begin
            p = d ? p - 1 : p + 1;
            op = rom_op(p);
            m_ops[n] = op;
            n++;
            if (op[0]) begin outcome = 1; break; end
            if (d) begin
                deeper    = op[5] && !op[4];
                shallower = op[4];
            end else begin
                deeper    = op[4];
                shallower = op[5] && !op[4];
            end
            if (deeper) begin
                if (depth == MAXD) begin outcome = 1; break; end
                depth++;
            end else if (shallower) begin
                depth--;
            end
            if (depth == 0) begin outcome = 0; break; end
        end
        endp = p;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; request = 1'b0; seek = 1'b0; dir = 1'b0;
        #1;
        chk("reset_state", outs(), mk(0, 0, 0, 0, 0, 1, 0, 16'h0000));
        @(negedge clk);
        rst = 1'b0;
        m_insn = 16'h0000; m_rev = 1'b0; m_err = 1'b0;
    endtask

    task automatic set_ip(input int v);
        env_set_val = v;
        env_set = 1'b1;
        @(posedge clk);
        #1 env_set = 1'b0;
        @(negedge clk);
        m_ip = v;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            request = 1'b0; seek = 1'b0;
            @(negedge clk);
            chk("idle", outs(), mk(0, 0, m_rev, 0, 0, !m_err, m_err, m_insn));
        end
    endtask

    // Issue one command from IDLE and check every cycle until it completes.
    task automatic run_cmd(input logic req, input logic sk, input logic d);
        int n, endp, outc;
        logic rexp, last;
        logic [15:0] ins;
        if (sk) begin
            model_seek(m_ip, d, n, endp, outc);
            rexp = d;
        end else begin
            n = 1; endp = m_ip + 1; m_ops[0] = rom_op(endp); outc = 2; rexp = 1'b0;
        end
        request = req; seek = sk; dir = d;
        @(posedge clk);
        for (int c = 0; c <= 3 * n; c++) begin
            @(negedge clk);
            last = (c == 3 * n);
            ins  = (c >= 3) ? m_ops[c / 3 - 1] : m_insn;
            chk($sformatf("%s_c%0d", sk ? "seek" : "fetch", c), outs(),
                mk(!last && (c % 3 == 0), !last && (c % 3 == 1), rexp,
                   last && outc == 2, last && outc == 0, last && outc != 1,
                   last && outc == 1, ins));
            if (!last) begin
                request = 1'($urandom_range(0, 1));
                seek    = 1'($urandom_range(0, 1));
                dir     = 1'($urandom_range(0, 1));
            end else begin
                request = 1'b0; seek = 1'b0; dir = 1'b0;
            end
        end
        chk("ip_final", env_ip, endp);
        last_n = n; m_insn = m_ops[n - 1]; m_rev = rexp; m_ip = endp;
        if (outc == 1) begin
            m_err = 1'b1;
            for (int i = 0; i < 5; i++) begin
                request = 1'b1; seek = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("err_hold", outs(), mk(0, 0, m_rev, 0, 0, 0, 1, m_insn));
            end
            request = 1'b0; seek = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single fetch from before a "+-" program
        load_prog("+-");
        do_reset();
        set_ip(-1);
        idle(2);
        run_cmd(1'b1, 1'b0, 1'b0);
        chk("t1_insn", o_insn, 16'h0002);
        idle(1);

        // 2: forward seek from the first '['
        load_prog("[+[-]>]");
        do_reset();
        set_ip(0);
        run_cmd(1'b0, 1'b1, 1'b0);
        chk("t2_iters", last_n, 6);
        chk("t2_ip", env_ip, 6);
        chk("t2_insn", o_insn, 16'h0020);
        idle(2);

        // 3: backward seek back to the start; Reverse holds afterwards
        run_cmd(1'b0, 1'b1, 1'b1);
        chk("t3_ip", env_ip, 0);
        chk("t3_insn", o_insn, 16'h0010);
        idle(2);
        run_cmd(1'b1, 1'b0, 1'b0);

        // 4: unmatched bracket runs into HALT
        load_prog("[++");
        do_reset();
        set_ip(0);
        run_cmd(1'b0, 1'b1, 1'b0);
        chk("t4_error", {o_error, o_ready}, 2'b10);
        chk("t4_iters", last_n, 3);

        // 5: nesting overflow with a 2-bit depth counter
        load_prog("[[[[[]]]]]");
        do_reset();
        set_ip(0);
        run_cmd(1'b0, 1'b1, 1'b0);
        chk("t5_iters", last_n, 3);
        chk("t5_error", o_error, 1'b1);

        // 6: Seek and Request together -> seek wins; reset mid-seek
        load_prog("[+[-]>]");
        do_reset();
        set_ip(6);
        request = 1'b1; seek = 1'b1; dir = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_seek_taken", {o_count, o_reverse, o_ready}, 3'b110);
        request = 1'b0; seek = 1'b0; dir = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("t6_mid_reset", outs(), mk(0, 0, 0, 0, 0, 1, 0, 16'h0000));
        @(negedge clk);
        rst = 1'b0;
        m_insn = 16'h0000; m_rev = 1'b0; m_err = 1'b0;
        idle(25);

        // Randomized programs and command streams
        for (int prog = 0; prog < 20; prog++) begin
            string s;
            string alpha;
            int len;
            alpha = "+-<>.,[][]";
            len = $urandom_range(8, 24);
            s = "";
            for (int i = 0; i < len; i++) begin
                byte ch;
                ch = alpha[$urandom_range(0, alpha.len() - 1)];
                s = {s, string'(ch)};
            end
            load_prog(s);
            do_reset();
            set_ip($urandom_range(0, len - 1));
            for (int k = 0; k < 30 && !m_err; k++) begin
                int sel;
                sel = $urandom_range(0, 99);
                if (sel < 50)
                    run_cmd(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                else if (sel < 85)
                    run_cmd(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
                else
                    idle($urandom_range(1, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
